fifo_wr_arbiter: RTL

Round-robin write arbiter that shares one 16x8 FIFO between four producers. Each producer presents a word with a request; the arbiter grants one per cycle and drives the FIFO write port through a registered stage. It keeps its own occupancy count, so grants stop before the FIFO can overflow despite the one-cycle write latency. It sits directly in front of the FIFO write side and shares the FIFO's clock and reset. The read side is driven by the consumer and observed by the arbiter.

---
 rtl/fifo_wr_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO between four producers.
// Registers the FIFO write port and tracks committed occupancy, in-flight write included.
module fifo_wr_arbiter #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned LW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    req,
    input  logic [DW-1:0] data0,
    input  logic [DW-1:0] data1,
    input  logic [DW-1:0] data2,
    input  logic [DW-1:0] data3,
    output logic [3:0]    gnt,
    output logic          fifo_we,
    output logic [DW-1:0] fifo_din,
    input  logic          fifo_re,
    input  logic          fifo_empty,
    output logic [LW-1:0] level
);

    localparam int unsigned NREQ = 4;
    localparam int unsigned PW   = 2;

    logic [PW-1:0] ptr_q,      ptr_d;
    logic [LW-1:0] level_q,    level_d;
    logic          fifo_we_q,  fifo_we_d;
    logic [DW-1:0] fifo_din_q, fifo_din_d;

    logic [PW-1:0] idx;
    logic [PW-1:0] win_idx;
    logic          found;
    logic          wr;
    logic          rd;
    logic [DW-1:0] win_data;

    // Search req starting at ptr; grant only below full and out of reset.
    always_comb begin
        idx     = '0;
        win_idx = '0;
        found   = 1'b0;
        gnt     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = ptr_q + PW'(k);
            if (!found && req[idx]) begin
                found   = 1'b1;
                win_idx = idx;
            end
        end
        if (found && (level_q < LW'(DEPTH)) && rst) begin
            gnt[win_idx] = 1'b1;
        end
    end

    always_comb begin
        win_data = data0;
        case (win_idx)
            2'd0:    win_data = data0;
            2'd1:    win_data = data1;
            2'd2:    win_data = data2;
            default: win_data = data3;
        endcase
    end

    assign wr = |(req & gnt);
    assign rd = fifo_re && !fifo_empty;

    // Next-state: registered write port, pointer advance and saturating level.
    always_comb begin
        fifo_we_d  = wr;
        fifo_din_d = fifo_din_q;
        ptr_d      = ptr_q;
        level_d    = level_q;
        if (wr) begin
            fifo_din_d = win_data;
            ptr_d      = win_idx + PW'(1);
        end
        if (wr && !rd) begin
            if (level_q < LW'(DEPTH)) begin
                level_d = level_q + LW'(1);
            end
        end else if (rd && !wr) begin
            if (level_q != '0) begin
                level_d = level_q - LW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q      <= '0;
            level_q    <= '0;
            fifo_we_q  <= 1'b0;
            fifo_din_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            level_q    <= level_d;
            fifo_we_q  <= fifo_we_d;
            fifo_din_q <= fifo_din_d;
        end
    end

    assign fifo_we  = fifo_we_q;
    assign fifo_din = fifo_din_q;
    assign level    = level_q;

endmodule
